divisor_param: RTL and testbench
================================

DIVISOR_PARAM -- requirements
Module: divisor_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand, quotient and remainder width in bits, legal range 4..64.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-004 SHALL have port start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 SHALL have port signed_op  input  1  1 = two's-complement division, 0 = unsigned; sampled with start.
REQ-006 SHALL have port A  input  WIDTH  dividend; sampled with start.
REQ-007 SHALL have port B  input  WIDTH  divisor; sampled with start.
REQ-008 SHALL have port lo  output  WIDTH  quotient, registered.
REQ-009 SHALL have port hi  output  WIDTH  remainder, registered.
REQ-010 SHALL have port busy  output  1  high while in any state other than IDLE.
REQ-011 SHALL have port done  output  1  single-cycle pulse; lo/hi/div0 valid from this cycle.
REQ-012 SHALL have port div0  output  1  divide-by-zero flag of the last accepted operation.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FIX, DONE; encoding free.
REQ-014 IDLE: start=1 and B!=0 -> latch operand magnitudes (per signed_op), result signs, clear iteration counter, clear div0, go RUN.
REQ-015 IDLE: start=1 and B==0 -> go DONE directly, set div0=1, lo=all ones, hi=A; no iterations.
REQ-016 RUN: one restoring step per cycle (shift partial remainder left by one, bring in next dividend bit, subtract divisor if result non-negative, shift quotient bit in); exactly WIDTH cycles, then go FIX.
REQ-017 FIX: quotient negated if signs of A and B differ (signed_op=1 only); remainder negated if A negative (signed_op=1 only); load lo/hi; go DONE.
REQ-018 DONE: done=1 for exactly that one cycle; next state IDLE.
REQ-019 Latency: done high in the cycle starting WIDTH+2 rising edges after the edge that samples start (B!=0); 1 edge for B==0.
REQ-020 Signed results: quotient truncates toward zero; remainder has sign of dividend; A = lo*B + hi holds modulo 2^WIDTH.
REQ-021 Signed overflow (A = most negative, B = -1): lo = most negative value, hi = 0, div0=0; no other flag.
REQ-022 Unsigned mode: operands treated as 0..2^WIDTH-1, no negation in FIX.
REQ-023 start while busy=1 SHALL be ignored; in-flight operands unaffected by changes on A, B, signed_op.
REQ-024 lo, hi, div0 SHALL hold their values from DONE until the next accepted start modifies them.
REQ-025 Internal partial remainder SHALL be WIDTH+1 bits to avoid loss on subtraction.

Reset
REQ-026 reset=1 SHALL force state IDLE, lo=0, hi=0, busy=0, done=0, div0=0, counter and internal registers 0, on the next rising edge.
REQ-027 reset SHALL take priority over start on the same edge and SHALL abort any operation in RUN/FIX/DONE without asserting done.

Configuration
REQ-028 Macro DIVISOR_PARAM_SIGNED_EN defined: signed_op honoured as in REQ-017/020/021.
REQ-029 Macro DIVISOR_PARAM_SIGNED_EN undefined: signed_op port present but ignored; every operation unsigned; no negation logic synthesised.

Verification (WIDTH=32, macro defined unless stated)
REQ-030 Unsigned A=100, B=7, start pulse -> busy 34 cycles, done in cycle 34 after start edge, lo=14, hi=2, div0=0.
REQ-031 Signed A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); signed A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-032 A=5, B=0 -> done next cycle, div0=1, lo=0xFFFFFFFF, hi=5; following valid op 9/3 -> div0=0, lo=3, hi=0.
REQ-033 Start 100/7, reset asserted at cycle 10 -> no done pulse, all outputs 0, busy=0; new start afterwards completes normally.
REQ-034 Start 100/7, second start with A=50, B=5 at cycle 5 -> ignored, result lo=14, hi=2, single done pulse.
REQ-035 Macro undefined, signed_op=1, A=0xFFFFFFF9, B=2 -> lo=0x7FFFFFFC, hi=1.

Source files
------------

// File: rtl/divisor_param.sv
// divisor_param: multi-cycle restoring divider, unsigned or (with DIVISOR_PARAM_SIGNED_EN) two's-complement.
module divisor_param #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             busy,
  output logic             done,
  output logic             div0
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo, r_div, r_lo, r_hi;
  logic [CW-1:0]    r_cnt;
  logic             r_div0;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_lo, w_hi;
  logic [WIDTH+1:0] w_shift, w_sub;
  logic             w_b_zero, w_last, w_accept;
  assign w_b_zero = B == '0;
  assign w_last   = r_cnt == CW'(WIDTH - 1);
  assign w_accept = r_state == IDLE && start;
  assign w_shift  = {r_rem, r_quo[WIDTH-1]};
  assign w_sub    = w_shift - {2'b00, r_div};
`ifdef DIVISOR_PARAM_SIGNED_EN
  logic r_neg_q, r_neg_r;
  logic w_a_neg, w_b_neg;
  assign w_a_neg = signed_op && A[WIDTH-1];
  assign w_b_neg = signed_op && B[WIDTH-1];
  assign w_a_mag = w_a_neg ? -A : A;
  assign w_b_mag = w_b_neg ? -B : B;
  assign w_lo    = r_neg_q ? -r_quo : r_quo;
  assign w_hi    = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
  always_ff @(posedge clock) begin
    if (reset) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept && !w_b_zero) begin
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end
  end
`else
  logic w_unused;
  assign w_unused = signed_op;
  assign w_a_mag  = A;
  assign w_b_mag  = B;
  assign w_lo     = r_quo;
  assign w_hi     = r_rem[WIDTH-1:0];
`endif
  always_comb begin
    w_next = r_state == IDLE ? (start ? (w_b_zero ? DONE : RUN) : IDLE) :
             r_state == RUN  ? (w_last ? FIX : RUN) :
             r_state == FIX  ? DONE : IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end
  // Dividend bits shift out of r_quo's top as quotient bits shift into its bottom.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_lo   <= '0;
      r_hi   <= '0;
      r_div0 <= 1'b0;
    end else if (w_accept) begin
      if (w_b_zero) begin
        r_lo   <= '1;
        r_hi   <= A;
        r_div0 <= 1'b1;
      end else begin
        r_rem  <= '0;
        r_quo  <= w_a_mag;
        r_div  <= w_b_mag;
        r_cnt  <= '0;
        r_div0 <= 1'b0;
      end
    end else if (r_state == RUN) begin
      r_rem <= w_sub[WIDTH+1] ? w_shift[WIDTH:0] : w_sub[WIDTH:0];
      r_quo <= {r_quo[WIDTH-2:0], ~w_sub[WIDTH+1]};
      r_cnt <= r_cnt + CW'(1);
    end else if (r_state == FIX) begin
      r_lo <= w_lo;
      r_hi <= w_hi;
    end
  end
  assign lo   = r_lo;
  assign hi   = r_hi;
  assign div0 = r_div0;
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
endmodule

// File: tb/tb_divisor_param.sv
// tb_divisor_param: directed and random divisions checked against an arithmetic model.
module tb_divisor_param;
`ifdef DIVISOR_PARAM_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif
  logic        clock = 1'b0, reset = 1'b1, start = 1'b0, signed_op = 1'b0;
  logic [31:0] A = '0, B = '0, lo, hi;
  logic        busy, done, div0;
  int          n_tests = 0, n_fail = 0;
  divisor_param #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .signed_op(signed_op),
    .A(A), .B(B), .lo(lo), .hi(hi), .busy(busy), .done(done), .div0(div0)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    z = b == 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (z) begin
      q = '1;
      r = a;
    end else if (s && SIGNED_EN) begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eq, er;
    logic        ez;
    int          cyc = 0, k = 0;
    model(s, a, b, eq, er, ez);
    @(negedge clock);
    start = 1'b1; signed_op = s; A = a; B = b;
    while (cyc == 0 && k < 60) begin
      @(negedge clock);
      k++;
      if (done) begin
        cyc = k;
        check("busy_in_done", busy, 1'b1);
        start = 1'b0;
      end else begin
        start = 1'($urandom_range(0, 1)); signed_op = 1'($urandom_range(0, 1));
        A = $urandom; B = $urandom;
      end
    end
    start = 1'b0;
    check("latency", cyc, ez ? 1 : 34);
    check("lo", lo, eq);
    check("hi", hi, er);
    check("div0", div0, ez);
    @(negedge clock);
    check("done_pulse", {busy, done}, 2'b00);
    A = $urandom; B = $urandom;
    repeat (2) @(negedge clock);
    check("hold", {lo, hi}, {eq, er});
  endtask
  initial begin
    int seen;
    logic [31:0] a, b;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("rst_out", {lo, hi, busy, done, div0}, '0);
    do_op(0, 100, 7);
    check("u100_7", {lo, hi}, {32'd14, 32'd2});
    do_op(1, 32'hFFFF_FFF9, 2);
    check("neg7_2", {lo, hi}, SIGNED_EN ? {32'hFFFF_FFFD, 32'hFFFF_FFFF} : {32'h7FFF_FFFC, 32'd1});
    do_op(1, 32'h8000_0000, 32'hFFFF_FFFF);
    check("ovf", {lo, hi, 31'd0, div0}, SIGNED_EN ? {32'h8000_0000, 32'd0, 32'd0} : {32'd0, 32'h8000_0000, 32'd0});
    do_op(0, 5, 0);
    check("div_zero", {lo, hi, 31'd0, div0}, {32'hFFFF_FFFF, 32'd5, 32'd1});
    do_op(0, 9, 3);
    check("after_zero", {lo, hi, 31'd0, div0}, {32'd3, 32'd0, 32'd0});
    do_op(0, 5, 0);
    @(negedge clock);
    start = 1'b1; A = 100; B = 7; signed_op = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clock);
      start = 1'b0;
      if (done) seen++;
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    if (done) seen++;
    check("abort_out", {lo, hi, busy, done, div0}, '0);
    repeat (30) begin
      @(negedge clock);
      if (done) seen++;
    end
    check("abort_nodone", seen, 0);
    do_op(0, 100, 7);
    for (int i = 0; i < 40; i++) begin
      a = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 0;
        1, 2:    b = $urandom_range(1, 20);
        3, 4:    b = -32'($urandom_range(1, 20));
        5:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      do_op(1'($urandom_range(0, 1)), a, b);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
